// File: rtl/spatial_filter_frame_ctrl.sv
// -----------------------------------------------------------------------------
// spatial_filter_frame_ctrl
//
// Frame sequencer between the AXI-Stream pixel input and the line-buffer
// controller of the 3x3 spatial filter. Real pixels are forwarded while the
// line buffers have room. After the last real row, FLUSH_LINES rows of zero
// pixels are injected so the window can drain the bottom image lines. A
// one-cycle frame-done pulse follows, and the block returns to idle.
//
// Ports
//   axis_clk         clock, rising edge
//   axis_reset       asynchronous, active-high reset
//   i_start          arms a frame (honoured only while idle)
//   i_abort          synchronous return to idle, wins over everything else
//   i_s_data_valid   input pixel valid
//   i_s_data         input pixel
//   o_s_ready        input ready (combinational)
//   o_lb_data        pixel to line-buffer controller (registered)
//   o_lb_data_valid  pixel valid to line-buffer controller (registered)
//   i_lb_full        downstream prog-full, blocks issue while high
//   o_busy           frame in progress (ACTIVE or FLUSH)
//   o_col            column of the next pixel to issue
//   o_row            row of the next pixel to issue
//   o_frame_done     one-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module spatial_filter_frame_ctrl #(
    parameter int PIXEL_SIZE   = 32,
    parameter int IMAGE_WIDTH  = 512,
    parameter int IMAGE_HEIGHT = 512,
    parameter int FLUSH_LINES  = 2,
    localparam int COL_W = $clog2(IMAGE_WIDTH),
    localparam int ROW_W = $clog2(IMAGE_HEIGHT + FLUSH_LINES)
) (
    input  logic                  axis_clk,
    input  logic                  axis_reset,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic                  i_s_data_valid,
    input  logic [PIXEL_SIZE-1:0] i_s_data,
    output logic                  o_s_ready,
    output logic [PIXEL_SIZE-1:0] o_lb_data,
    output logic                  o_lb_data_valid,
    input  logic                  i_lb_full,
    output logic                  o_busy,
    output logic [COL_W-1:0]      o_col,
    output logic [ROW_W-1:0]      o_row,
    output logic                  o_frame_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [COL_W-1:0] COL_LAST       = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST_REAL  = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_LAST_FLUSH = ROW_W'(IMAGE_HEIGHT + FLUSH_LINES - 1);

    state_t                  state_reg, state_next;
    logic [COL_W-1:0]        col_reg, col_next;
    logic [ROW_W-1:0]        row_reg, row_next;
    logic [PIXEL_SIZE-1:0]   lb_data_reg;
    logic                    lb_valid_reg;
    logic                    busy_reg;
    logic                    done_reg;

    // One pixel leaves toward the line buffers this cycle
    logic                    send;
    logic [PIXEL_SIZE-1:0]   send_data;
    logic                    col_last;

    assign col_last = (col_reg == COL_LAST);

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        send       = 1'b0;
        send_data  = '0;

        case (state_reg)
            IDLE: begin
                if (i_start && !i_abort) begin
                    state_next = ACTIVE;
                    col_next   = '0;
                    row_next   = '0;
                end
            end
            ACTIVE, FLUSH: begin
                if (i_abort) begin
                    state_next = IDLE;
                    col_next   = '0;
                    row_next   = '0;
                end else if (!i_lb_full && (state_reg == FLUSH || i_s_data_valid)) begin
                    send      = 1'b1;
                    send_data = (state_reg == ACTIVE) ? i_s_data : '0;
                    if (col_last) begin
                        col_next = '0;
                        row_next = row_reg + ROW_W'(1);
                    end else begin
                        col_next = col_reg + COL_W'(1);
                    end
                    if (col_last && state_reg == ACTIVE && row_reg == ROW_LAST_REAL) begin
                        // Row keeps counting into the flush rows
                        state_next = FLUSH;
                    end
                    if (col_last && state_reg == FLUSH && row_reg == ROW_LAST_FLUSH) begin
                        // Counters read zero whenever no frame is in progress
                        state_next = DONE;
                        row_next   = '0;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            state_reg    <= IDLE;
            col_reg      <= '0;
            row_reg      <= '0;
            lb_data_reg  <= '0;
            lb_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            col_reg      <= col_next;
            row_reg      <= row_next;
            lb_valid_reg <= send;
            if (send) begin
                lb_data_reg <= send_data;
            end
            // Registered decodes of the upcoming state, so they track the state exactly
            busy_reg     <= (state_next == ACTIVE) || (state_next == FLUSH);
            done_reg     <= (state_next == DONE);
        end
    end

    assign o_s_ready       = (state_reg == ACTIVE) && !i_lb_full && !i_abort;
    assign o_lb_data       = lb_data_reg;
    assign o_lb_data_valid = lb_valid_reg;
    assign o_busy          = busy_reg;
    assign o_col           = col_reg;
    assign o_row           = row_reg;
    assign o_frame_done    = done_reg;

endmodule

// File: tb/tb_spatial_filter_frame_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for spatial_filter_frame_ctrl (IMAGE_WIDTH=4, IMAGE_HEIGHT=3,
// FLUSH_LINES=1). A frame model counts pixels sent in the current frame and
// derives every output from that count; it is compared on each falling edge.
// Directed scenarios add literal expectations on beat sequences and timing.
// -----------------------------------------------------------------------------
module tb_spatial_filter_frame_ctrl;

    localparam int PS    = 32;
    localparam int W     = 4;
    localparam int H     = 3;
    localparam int F     = 1;
    localparam int REAL  = W * H;
    localparam int TOTAL = W * (H + F);

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start, i_abort, i_s_data_valid, i_lb_full;
    logic [PS-1:0] i_s_data;
    logic          o_s_ready, o_lb_data_valid, o_busy, o_frame_done;
    logic [PS-1:0] o_lb_data;
    logic [1:0]    o_col, o_row;

    always #5 clk = ~clk;

    spatial_filter_frame_ctrl #(
        .PIXEL_SIZE  (PS),
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .FLUSH_LINES (F)
    ) dut (
        .axis_clk       (clk),
        .axis_reset     (rst),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .i_s_data_valid (i_s_data_valid),
        .i_s_data       (i_s_data),
        .o_s_ready      (o_s_ready),
        .o_lb_data      (o_lb_data),
        .o_lb_data_valid(o_lb_data_valid),
        .i_lb_full      (i_lb_full),
        .o_busy         (o_busy),
        .o_col          (o_col),
        .o_row          (o_row),
        .o_frame_done   (o_frame_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame model: k = pixels sent so far in this frame
    bit          m_run, m_valid, m_done;
    int          m_k;
    logic [PS-1:0] m_data;
    bit          rn, vn, dn;
    int          kn;
    logic [PS-1:0] dd;

    always_comb begin
        rn = m_run;
        kn = m_k;
        vn = 1'b0;
        dn = 1'b0;
        dd = m_data;
        if (i_abort) begin
            rn = 1'b0;
            kn = 0;
        end else if (m_run) begin
            if (m_k < REAL) begin
                if (i_s_data_valid && !i_lb_full) begin
                    vn = 1'b1;
                    dd = i_s_data;
                    kn = kn + 1;
                end
            end else if (!i_lb_full) begin
                vn = 1'b1;
                dd = '0;
                kn = kn + 1;
            end
            if (kn == TOTAL) begin
                rn = 1'b0;
                kn = 0;
                dn = 1'b1;
            end
        end else if (i_start && !m_done) begin
            rn = 1'b1;
            kn = 0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run   <= 1'b0;
            m_k     <= 0;
            m_valid <= 1'b0;
            m_done  <= 1'b0;
            m_data  <= '0;
        end else begin
            m_run   <= rn;
            m_k     <= kn;
            m_valid <= vn;
            m_done  <= dn;
            m_data  <= dd;
        end
    end

    // ---------------- per-cycle compare and output monitor
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [PS-1:0] out_q[$];
    int done_cnt, busy_cnt, done_cyc, start_cyc;

    always @(negedge clk) begin
        chk("ready",    64'(o_s_ready),       64'(m_run && (m_k < REAL) && !i_lb_full && !i_abort));
        chk("lb_valid", 64'(o_lb_data_valid), 64'(m_valid));
        chk("lb_data",  64'(o_lb_data),       64'(m_data));
        chk("busy",     64'(o_busy),          64'(m_run));
        chk("col",      64'(o_col),           64'(m_k % W));
        chk("row",      64'(o_row),           64'(m_k / W));
        chk("done",     64'(o_frame_done),    64'(m_done));
        if (o_lb_data_valid) out_q.push_back(o_lb_data);
        if (o_frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (o_busy) busy_cnt++;
    end

    // ---------------- stimulus helpers
    task automatic idle_inputs();
        i_start = 0; i_abort = 0; i_s_data_valid = 0; i_s_data = '0; i_lb_full = 0;
    endtask

    // Start a frame, then for ncyc cycles present pixels 1..n, full in
    // [ff, ff+fl), extra starts at cycles s1/s2, abort while pixel abort_pix is offered.
    task automatic run(input int n, input int ncyc, input int ff, input int fl,
                       input int abort_pix, input int s1, input int s2);
        int  p;
        bit  acc;
        p = 1;
        @(posedge clk); #1;
        out_q.delete();
        done_cnt = 0; busy_cnt = 0; done_cyc = -1;
        start_cyc = cyc;
        i_start = 1;
        @(posedge clk); #1;
        i_start = 0;
        for (int c = 0; c < ncyc; c++) begin
            i_s_data_valid = (p <= n);
            i_s_data       = (p <= n) ? PS'(p) : '0;
            i_lb_full      = (c >= ff) && (c < ff + fl);
            i_start        = (c == s1) || (c == s2);
            i_abort        = (p == abort_pix);
            #2 acc = i_s_data_valid && o_s_ready;
            @(posedge clk); #1;
            if (i_abort) begin
                chk("abort col",   64'(o_col), 64'd0);
                chk("abort row",   64'(o_row), 64'd0);
                chk("abort busy",  64'(o_busy), 64'd0);
                chk("abort valid", 64'(o_lb_data_valid), 64'd0);
                idle_inputs();
                return;
            end
            if (acc) p++;
        end
        idle_inputs();
    endtask

    task automatic check_frame(input string tag, input int exp_len);
        chk({tag, " beats"}, 64'(out_q.size()), 64'(exp_len));
        for (int i = 0; i < out_q.size() && i < exp_len; i++)
            chk($sformatf("%s beat%0d", tag, i), 64'(out_q[i]), (i < REAL) ? 64'(i + 1) : 64'd0);
    endtask

    task automatic check_done(input string tag, input int delay);
        chk({tag, " done_cnt"}, 64'(done_cnt), 64'd1);
        chk({tag, " done_cyc"}, 64'(done_cyc - start_cyc), 64'(1 + TOTAL + delay));
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        #3;
        chk("rst ready", 64'(o_s_ready), 64'd0);
        chk("rst data",  64'(o_lb_data), 64'd0);
        chk("rst busy",  64'(o_busy), 64'd0);
        chk("rst done",  64'(o_frame_done), 64'd0);
        @(posedge clk); @(posedge clk); #3;
        rst = 0;

        // Nominal frame
        run(REAL, 22, 99, 0, 0, -1, -1);
        check_frame("nominal", TOTAL);
        check_done("nominal", 0);
        chk("nominal busy_cnt", 64'(busy_cnt), 64'(TOTAL));
        $display("nominal frame: %0d beats, done at +%0d", out_q.size(), done_cyc - start_cyc);

        // Back-pressure mid row 1 (3 cycles)
        run(REAL, 24, 5, 3, 0, -1, -1);
        check_frame("bp_row", TOTAL);
        check_done("bp_row", 3);
        $display("row back-pressure frame: %0d beats, done at +%0d", out_q.size(), done_cyc - start_cyc);

        // Back-pressure during flush after the second zero
        run(REAL, 24, 14, 2, 0, -1, -1);
        check_frame("bp_flush", TOTAL);
        check_done("bp_flush", 2);
        $display("flush back-pressure frame: %0d beats, done at +%0d", out_q.size(), done_cyc - start_cyc);

        // Abort while pixel 7 is offered
        run(REAL, 22, 99, 0, 7, -1, -1);
        repeat (5) @(posedge clk);
        #1;
        chk("abort done_cnt", 64'(done_cnt), 64'd0);
        check_frame("abort", 6);
        $display("aborted frame: %0d beats before abort", out_q.size());
        run(REAL, 22, 99, 0, 0, -1, -1);
        check_frame("restart", TOTAL);
        check_done("restart", 0);
        $display("restart frame: %0d beats", out_q.size());

        // Idle gating: valid high in IDLE, extra starts in ACTIVE and DONE
        i_s_data_valid = 1; i_s_data = 32'd99;
        repeat (3) @(posedge clk);
        #1;
        chk("idle ready", 64'(o_s_ready), 64'd0);
        run(REAL, 24, 99, 0, 0, 3, TOTAL);
        check_frame("gating", TOTAL);
        check_done("gating", 0);
        chk("gating busy_cnt", 64'(busy_cnt), 64'(TOTAL));
        chk("gating idle busy", 64'(o_busy), 64'd0);
        $display("gating frame: %0d beats, %0d busy cycles", out_q.size(), busy_cnt);

        // Async reset during flush
        run(REAL, 14, 99, 0, 0, -1, -1);
        #1;
        chk("pre-rst valid", 64'(o_lb_data_valid), 64'd1);
        rst = 1;
        #1;
        chk("async ready", 64'(o_s_ready), 64'd0);
        chk("async data",  64'(o_lb_data), 64'd0);
        chk("async valid", 64'(o_lb_data_valid), 64'd0);
        chk("async busy",  64'(o_busy), 64'd0);
        chk("async col",   64'(o_col), 64'd0);
        chk("async row",   64'(o_row), 64'd0);
        chk("async done",  64'(o_frame_done), 64'd0);
        $display("async reset applied mid-flush");
        @(posedge clk); @(posedge clk); #3;
        rst = 0;
        run(REAL, 22, 99, 0, 0, -1, -1);
        check_frame("post_rst", TOTAL);
        check_done("post_rst", 0);
        $display("post-reset frame: %0d beats", out_q.size());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
